ddr3_rw_arbiter: RTL and testbench

//  Sits between the 16<->128-bit FIFO controller and the MIG user interface, in the ui_clk domain.
//  It moves BURST_LEN-beat bursts from the write FIFO into DDR3 and from DDR3 into the read FIFO,

---
 rtl/ddr3_rw_arbiter.sv | 99 +++++++++
 tb/tb_ddr3_rw_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: moves BURST_LEN-beat bursts between the FIFO controller and the MIG user interface
module ddr3_rw_arbiter #(
  parameter logic [27:0] ADDR_MIN  = 28'd0,
  parameter logic [27:0] ADDR_MAX  = 28'd1048576,
  parameter logic [9:0]  BURST_LEN = 10'd64
) (
  input  logic         ui_clk,
  input  logic         rst,
  input  logic         init_calib_complete,
  input  logic         app_rdy,
  input  logic         app_wdf_rdy,
  input  logic         app_rd_data_valid,
  input  logic [127:0] app_rd_data,
  input  logic [9:0]   wfifo_rcount,
  input  logic [9:0]   rfifo_wcount,
  input  logic         wr_load,
  input  logic         rd_load,
  output logic [27:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic         wfifo_rden,
  output logic         rfifo_wren,
  output logic [127:0] rfifo_din
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_RDRAIN = 3'd4;
  logic [2:0]  r_state;
  logic [9:0]  r_cnt, r_ret_cnt;
  logic [27:0] r_wr_addr, r_rd_addr;
  logic        r_frame_valid, r_wr_pend, r_rd_pend;
  logic [2:0]  r_wl_sync, r_rl_sync;
  logic        w_wl_edge, w_rl_edge, w_arb, w_beat, w_rd_cmd, w_rd_acc, w_rd_ret;
  logic [27:0] w_wr_next, w_rd_next;
  assign w_wl_edge = r_wl_sync[1] & ~r_wl_sync[2];
  assign w_rl_edge = r_rl_sync[1] & ~r_rl_sync[2];
  assign w_arb     = (r_state == S_IDLE) | (r_state == S_ARB);
  assign w_beat    = (r_state == S_WRITE) & app_rdy & app_wdf_rdy & (r_cnt < BURST_LEN);
  assign w_rd_cmd  = (r_state == S_READ) & (r_cnt < BURST_LEN);
  assign w_rd_acc  = w_rd_cmd & app_rdy;
  assign w_rd_ret  = app_rd_data_valid & ((r_state == S_READ) | (r_state == S_RDRAIN));
  assign w_wr_next = (r_wr_addr == ADDR_MAX - 28'd8) ? ADDR_MIN : r_wr_addr + 28'd8;
  assign w_rd_next = (r_rd_addr == ADDR_MAX - 28'd8) ? ADDR_MIN : r_rd_addr + 28'd8;
  assign app_en       = w_beat | w_rd_cmd;
  assign app_cmd      = {2'b00, r_state == S_READ};
  assign app_wdf_wren = w_beat;
  assign app_wdf_end  = w_beat;
  assign wfifo_rden   = w_beat;
  assign rfifo_wren   = w_rd_ret;
  assign rfifo_din    = app_rd_data;
  assign app_addr     = (r_state == S_WRITE) ? r_wr_addr : r_rd_addr;
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ret_cnt     <= '0;
      r_wr_addr     <= ADDR_MIN;
      r_rd_addr     <= ADDR_MIN;
      r_frame_valid <= 1'b0;
      r_wr_pend     <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_wl_sync     <= '0;
      r_rl_sync     <= '0;
    end else begin
      r_wl_sync <= {r_wl_sync[1:0], wr_load};
      r_rl_sync <= {r_rl_sync[1:0], rd_load};
      // frame restarts seen mid-burst wait for ARB so a burst is never split
      r_wr_pend <= w_arb ? 1'b0 : (r_wr_pend | w_wl_edge);
      r_rd_pend <= w_arb ? 1'b0 : (r_rd_pend | w_rl_edge);
      r_wr_addr <= w_beat ? w_wr_next : (w_arb & (w_wl_edge | r_wr_pend)) ? ADDR_MIN : r_wr_addr;
      r_rd_addr <= w_rd_acc ? w_rd_next : (w_arb & (w_rl_edge | r_rd_pend)) ? ADDR_MIN : r_rd_addr;
      r_frame_valid <= r_frame_valid | (w_beat & (r_wr_addr == ADDR_MAX - 28'd8));
      r_ret_cnt <= w_rd_ret ? r_ret_cnt + 10'd1 : r_ret_cnt;
      case (r_state)
        S_IDLE: r_state <= init_calib_complete ? S_ARB : S_IDLE;
        S_ARB: begin
          r_cnt     <= '0;
          r_ret_cnt <= '0;
          if (wfifo_rcount >= BURST_LEN) r_state <= S_WRITE;
          else if (r_frame_valid && rfifo_wcount <= 10'd511 - BURST_LEN) r_state <= S_READ;
        end
        S_WRITE: begin
          r_cnt   <= w_beat ? r_cnt + 10'd1 : r_cnt;
          r_state <= (r_cnt == BURST_LEN) ? S_ARB : S_WRITE;
        end
        S_READ: begin
          r_cnt   <= w_rd_acc ? r_cnt + 10'd1 : r_cnt;
          r_state <= (w_rd_acc && r_cnt == BURST_LEN - 10'd1) ? S_RDRAIN : S_READ;
        end
        S_RDRAIN: r_state <= (r_ret_cnt == BURST_LEN) ? S_ARB : S_RDRAIN;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb_ddr3_rw_arbiter: randomized MIG handshakes checked against a transaction-level pointer/burst model
module tb_ddr3_rw_arbiter;
  localparam logic [27:0] AMIN = 28'd0;
  localparam logic [27:0] AMAX = 28'd2048;
  localparam int BL = 64;
  logic         ui_clk = 0, rst = 1, init_calib_complete = 0;
  logic         app_rdy = 0, app_wdf_rdy = 0, app_rd_data_valid = 0;
  logic [127:0] app_rd_data = '0;
  logic [9:0]   wfifo_rcount = 0, rfifo_wcount = 0;
  logic         wr_load = 0, rd_load = 0;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren;
  logic [127:0] rfifo_din;
  int errors = 0, checks = 0;
  int iss = 0, ret = 0, wstarts = 0, wdone = 0, rstarts = 0, rdone = 0, m_wcnt = 0, m_rcnt = 0;
  int wl_cnt = 0, wl_app = 0, rl_cnt = 0, rl_app = 0;
  logic [27:0] m_wr = AMIN, m_rd = AMIN;
  bit m_fv = 0, stall_wdf = 0;

  ddr3_rw_arbiter #(.ADDR_MIN(AMIN), .ADDR_MAX(AMAX), .BURST_LEN(10'd64)) dut (
    .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .wfifo_rcount(wfifo_rcount), .rfifo_wcount(rfifo_wcount),
    .wr_load(wr_load), .rd_load(rd_load), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .wfifo_rden(wfifo_rden), .rfifo_wren(rfifo_wren), .rfifo_din(rfifo_din));

  always #5 ui_clk = ~ui_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ui_clk);
    #1;
  endtask

  task automatic wait_ws(input int t);
    for (int k = 0; k < 4000 && wstarts < t; k++) cyc(1);
    chk("timeout_wstart", wstarts >= t, 1);
  endtask

  task automatic wait_wd(input int t);
    for (int k = 0; k < 4000 && wdone < t; k++) cyc(1);
    chk("timeout_wdone", wdone >= t, 1);
  endtask

  task automatic wait_rs(input int t);
    for (int k = 0; k < 4000 && rstarts < t; k++) cyc(1);
    chk("timeout_rstart", rstarts >= t, 1);
  endtask

  task automatic wait_rd(input int t);
    for (int k = 0; k < 4000 && rdone < t; k++) cyc(1);
    chk("timeout_rdone", rdone >= t, 1);
  endtask

  task automatic wait_wbeat(input int n);
    for (int k = 0; k < 4000 && m_wcnt < n; k++) cyc(1);
    chk("timeout_wbeat", m_wcnt >= n, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 4000 && !(rstarts == rdone && wstarts == wdone && iss == ret && !app_rd_data_valid); k++) cyc(1);
    chk("timeout_idle", rstarts == rdone && wstarts == wdone && iss == ret, 1);
    cyc(3);
  endtask

  // MIG model: random ready, read data returned for every accepted read command
  always @(posedge ui_clk) begin
    #1;
    app_rdy = ($urandom_range(0, 3) != 0);
    app_wdf_rdy = !stall_wdf && ($urandom_range(0, 3) != 0);
    if (rst) begin
      ret = 0;
      app_rd_data_valid = 0;
    end else if (iss > ret && $urandom_range(0, 2) != 0) begin
      app_rd_data_valid = 1;
      app_rd_data = {$urandom, $urandom, $urandom, $urandom};
      ret++;
    end else app_rd_data_valid = 0;
  end

  // reference model: burst framing, wrapping pointers, frame_valid, deferred reloads
  always @(negedge ui_clk) begin
    if (rst) begin
      m_wr = AMIN; m_rd = AMIN; m_fv = 0; m_wcnt = 0; m_rcnt = 0; iss = 0;
      wl_app = wl_cnt; rl_app = rl_cnt; wdone = wstarts; rdone = rstarts;
    end else begin
      chk("wstrobes", {app_wdf_wren, app_wdf_end, wfifo_rden}, {3{app_en && app_cmd == 3'd0}});
      chk("rfifo_wren", rfifo_wren, app_rd_data_valid);
      if (app_rd_data_valid) chk("rfifo_din", rfifo_din, app_rd_data);
      if (app_en) chk("cmd_legal", app_cmd <= 3'd1, 1);
      if (app_en && app_cmd == 3'd0) begin
        chk("wr_rdy", app_rdy & app_wdf_rdy, 1);
        if (m_wcnt == 0) begin
          chk("wr_after_drain", iss == ret && !app_rd_data_valid, 1);
          chk("wr_not_in_rd", m_rcnt, 0);
          wstarts++;
          if (wl_cnt != wl_app) begin m_wr = AMIN; wl_app = wl_cnt; end
        end
        chk("wr_addr", app_addr, m_wr);
        if (m_wr == AMAX - 28'd8) begin m_wr = AMIN; m_fv = 1; end
        else m_wr = m_wr + 28'd8;
        m_wcnt++;
        if (m_wcnt == BL) begin m_wcnt = 0; wdone++; end
      end
      if (app_en && app_cmd == 3'd1 && app_rdy) begin
        if (m_rcnt == 0) begin
          chk("rd_after_drain", iss == ret && !app_rd_data_valid, 1);
          chk("rd_not_in_wr", m_wcnt, 0);
          chk("rd_frame_valid", m_fv, 1);
          rstarts++;
          if (rl_cnt != rl_app) begin m_rd = AMIN; rl_app = rl_cnt; end
        end
        chk("rd_addr", app_addr, m_rd);
        m_rd = (m_rd == AMAX - 28'd8) ? AMIN : m_rd + 28'd8;
        iss++;
        m_rcnt++;
        if (m_rcnt == BL) begin m_rcnt = 0; rdone++; end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, c;
    wfifo_rcount = 10'd100;
    rfifo_wcount = 10'd500;
    cyc(3);
    chk("rst_en", app_en, 0);
    chk("rst_addr", app_addr, AMIN);
    chk("rst_cmd", app_cmd, 0);
    chk("rst_wstrobes", {app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren}, 0);
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk("no_calib_en", app_en, 0);
    end
    init_calib_complete = 1;
    wait_ws(1);
    wait_wbeat(20);
    stall_wdf = 1;
    cyc(1);
    c = m_wcnt;
    cyc(4);
    chk("stall_hold", m_wcnt, c);
    stall_wdf = 0;
    wfifo_rcount = 0;
    wait_wd(1);
    chk("first_burst_end", m_wr, AMIN + 28'd512);
    wfifo_rcount = 10'd63;
    cyc(40);
    chk("arb_63_w", wstarts, 1);
    chk("arb_63_r", rstarts, 0);
    wfifo_rcount = 10'd64;
    wait_ws(4);
    wfifo_rcount = 0;
    wait_wd(4);
    chk("wr_wrapped", m_wr, AMIN);
    chk("no_reads_yet", rstarts, 0);
    cyc(5);
    w0 = wstarts; r0 = rstarts;
    wfifo_rcount = 10'd100;
    rfifo_wcount = 10'd0;
    for (int k = 0; k < 100 && wstarts == w0 && rstarts == r0; k++) cyc(1);
    chk("prio_write", wstarts, w0 + 1);
    chk("prio_no_read", rstarts, r0);
    wfifo_rcount = 0;
    wait_wd(w0 + 1);
    wait_rd(2);
    rfifo_wcount = 10'd500;
    wait_idle();
    r0 = rstarts;
    rfifo_wcount = 10'd448;
    cyc(30);
    chk("rfifo_448", rstarts, r0);
    rfifo_wcount = 10'd447;
    wait_rs(r0 + 1);
    rfifo_wcount = 10'd500;
    wait_idle();
    rd_load = 1;
    rl_cnt++;
    cyc(3);
    rd_load = 0;
    cyc(10);
    r0 = rstarts;
    rfifo_wcount = 0;
    wait_rs(r0 + 1);
    rfifo_wcount = 10'd500;
    wait_idle();
    w0 = wstarts;
    wfifo_rcount = 10'd100;
    wait_ws(w0 + 1);
    wait_wbeat(30);
    wr_load = 1;
    wl_cnt++;
    cyc(3);
    wr_load = 0;
    wait_ws(w0 + 2);
    wfifo_rcount = 0;
    wait_wd(w0 + 2);
    chk("wload_burst", m_wr, AMIN + 28'd512);
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 3))
        0: wfifo_rcount = 10'd0;
        1: wfifo_rcount = 10'd63;
        2: wfifo_rcount = 10'd64;
        default: wfifo_rcount = 10'd200;
      endcase
      case ($urandom_range(0, 3))
        0: rfifo_wcount = 10'd0;
        1: rfifo_wcount = 10'd447;
        2: rfifo_wcount = 10'd448;
        default: rfifo_wcount = 10'd500;
      endcase
      cyc(60);
    end
    wfifo_rcount = 0;
    rfifo_wcount = 10'd500;
    wait_idle();
    rfifo_wcount = 0;
    r0 = rstarts;
    wait_rs(r0 + 1);
    for (int k = 0; k < 400 && m_rcnt < 10; k++) cyc(1);
    chk("reach_10_cmds", m_rcnt >= 10, 1);
    rst = 1;
    #1;
    chk("abort_en", app_en, 0);
    chk("abort_addr", app_addr, AMIN);
    chk("abort_cmd", app_cmd, 0);
    chk("abort_strobes", {app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren}, 0);
    cyc(3);
    rst = 0;
    r0 = rstarts;
    cyc(30);
    chk("fv_cleared", rstarts, r0);
    w0 = wstarts;
    wfifo_rcount = 10'd100;
    wait_ws(w0 + 1);
    wfifo_rcount = 0;
    wait_wd(w0 + 1);
    chk("post_rst_wr", m_wr, AMIN + 28'd512);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
